// File: rtl/handshaked_width_upsizer.sv
// rtl/handshaked_width_upsizer.sv - packs ITEMS narrow stream items into one masked wide output word
module handshaked_width_upsizer #(
  parameter int DATA_WIDTH = 2,
  parameter int ITEMS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       dataIn_data,
  input  logic                        dataIn_last,
  input  logic                        dataIn_vld,
  output logic                        dataIn_rd,
  output logic [DATA_WIDTH*ITEMS-1:0] dataOut_data,
  output logic [ITEMS-1:0]            dataOut_mask,
  output logic                        dataOut_last,
  output logic                        dataOut_vld,
  input  logic                        dataOut_rd
);

  localparam int IW = (ITEMS > 1) ? $clog2(ITEMS) : 1;
  localparam int OW = DATA_WIDTH * ITEMS;
  localparam logic [IW-1:0] LAST_IDX = IW'(ITEMS - 1);

  logic [IW-1:0]    idx_q, idx_d;
  logic [OW-1:0]    acc_data_q, acc_data_d;
  logic [ITEMS-1:0] acc_mask_q, acc_mask_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [ITEMS-1:0] out_mask_q, out_mask_d;
  logic             out_last_q, out_last_d;
  logic             out_vld_q, out_vld_d;

  logic             completing;
  logic             accept;
  logic [OW-1:0]    merged_data;
  logic [ITEMS-1:0] merged_mask;

  // Accumulator with the incoming item dropped into the current slot
  always_comb begin
    merged_data = acc_data_q;
    for (int k = 0; k < ITEMS; k++) begin
      if (idx_q == IW'(k)) begin
        merged_data[k*DATA_WIDTH +: DATA_WIDTH] = dataIn_data;
      end
    end
    merged_mask = acc_mask_q | (ITEMS'(1) << idx_q);
  end

  // Only the beat that closes a word needs room in the output register
  assign completing = (idx_q == LAST_IDX) || dataIn_last;
  assign dataIn_rd  = !rst && (!completing || !out_vld_q || dataOut_rd);
  assign accept     = dataIn_vld && dataIn_rd;

  always_comb begin
    idx_d      = idx_q;
    acc_data_d = acc_data_q;
    acc_mask_d = acc_mask_q;
    out_data_d = out_data_q;
    out_mask_d = out_mask_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;

    if (out_vld_q && dataOut_rd) begin
      out_vld_d = 1'b0;
    end

    if (accept) begin
      if (completing) begin
        out_data_d = merged_data;
        out_mask_d = merged_mask;
        out_last_d = dataIn_last;
        out_vld_d  = 1'b1;
        acc_data_d = '0;
        acc_mask_d = '0;
        idx_d      = '0;
      end else begin
        acc_data_d = merged_data;
        acc_mask_d = merged_mask;
        idx_d      = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      acc_data_q <= '0;
      acc_mask_q <= '0;
      out_data_q <= '0;
      out_mask_q <= '0;
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      acc_data_q <= acc_data_d;
      acc_mask_q <= acc_mask_d;
      out_data_q <= out_data_d;
      out_mask_q <= out_mask_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign dataOut_data = out_data_q;
  assign dataOut_mask = out_mask_q;
  assign dataOut_last = out_last_q;
  assign dataOut_vld  = out_vld_q;

endmodule

// File: tb/tb_handshaked_width_upsizer.sv
// tb/tb_handshaked_width_upsizer.sv - directed and randomized checks of the width upsizer
module tb_handshaked_width_upsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0] a_din;
  logic       a_last, a_vld, a_rd;
  logic [7:0] a_dout;
  logic [3:0] a_mask;
  logic       a_olast, a_ovld, a_ordy;

  logic [7:0] b_din;
  logic       b_last, b_vld, b_rd;
  logic [7:0] b_dout;
  logic [0:0] b_mask;
  logic       b_olast, b_ovld, b_ordy;

  handshaked_width_upsizer #(.DATA_WIDTH(2), .ITEMS(4)) u_a (
    .clk(clk), .rst(rst),
    .dataIn_data(a_din), .dataIn_last(a_last), .dataIn_vld(a_vld), .dataIn_rd(a_rd),
    .dataOut_data(a_dout), .dataOut_mask(a_mask), .dataOut_last(a_olast),
    .dataOut_vld(a_ovld), .dataOut_rd(a_ordy)
  );

  handshaked_width_upsizer #(.DATA_WIDTH(8), .ITEMS(1)) u_b (
    .clk(clk), .rst(rst),
    .dataIn_data(b_din), .dataIn_last(b_last), .dataIn_vld(b_vld), .dataIn_rd(b_rd),
    .dataOut_data(b_dout), .dataOut_mask(b_mask), .dataOut_last(b_olast),
    .dataOut_vld(b_ovld), .dataOut_rd(b_ordy)
  );

  int errors = 0;
  int checks = 0;
  bit mon_a_en = 1'b0;
  bit mon_b_en = 1'b0;
  logic [12:0] a_obs[$];
  logic [12:0] a_exp[$];
  logic [9:0]  b_obs[$];
  logic [9:0]  b_exp[$];

  // Output transfers happen at the next rising edge; inputs only move just after rising edges
  always @(negedge clk) begin
    if (mon_a_en && !rst && a_ovld && a_ordy) a_obs.push_back({a_olast, a_mask, a_dout});
    if (mon_b_en && !rst && b_ovld && b_ordy) b_obs.push_back({b_olast, b_mask, b_dout});
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack4(input int x0, input int x1, input int x2, input int x3);
    return 8'(x0 + x1 * 4 + x2 * 16 + x3 * 64);
  endfunction

  task automatic a_beat(input logic [1:0] d, input logic l, input bit rnd);
    int  n;
    bit  ok;
    n = 0;
    a_din = d; a_last = l; a_vld = 1'b1;
    while (1) begin
      if (rnd) a_ordy = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = a_rd;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n >= 300) begin
        chk("a_beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    a_vld = 1'b0;
  endtask

  task automatic b_beat(input logic [7:0] d, input logic l, input bit rnd);
    int  n;
    bit  ok;
    n = 0;
    b_din = d; b_last = l; b_vld = 1'b1;
    while (1) begin
      if (rnd) b_ordy = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = b_rd;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n >= 300) begin
        chk("b_beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    b_vld = 1'b0;
  endtask

  initial begin
    int s[16];
    logic [1:0] d;
    logic       l;
    logic [7:0] wd;
    logic [3:0] wm;
    int         cnt;
    logic [7:0] bd;

    rst = 1'b1;
    a_din = 2'd1; a_last = 1'b0; a_vld = 1'b1; a_ordy = 1'b1;
    b_din = 8'h11; b_last = 1'b0; b_vld = 1'b1; b_ordy = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_a_ovld", a_ovld, 0);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_a_dout", a_dout, 0);
    chk("rst_a_mask", a_mask, 0);
    chk("rst_a_olast", a_olast, 0);
    chk("rst_b_ovld", b_ovld, 0);
    chk("rst_b_rd", b_rd, 0);
    @(posedge clk); #1;
    rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;

    // full word
    a_beat(2'd1, 1'b0, 1'b0);
    a_beat(2'd2, 1'b0, 1'b0);
    a_beat(2'd3, 1'b0, 1'b0);
    a_beat(2'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_vld", a_ovld, 1);
    chk("full_data", a_dout, pack4(1, 2, 3, 0));
    chk("full_mask", a_mask, 4'hF);
    chk("full_last", a_olast, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_vld_one_cycle", a_ovld, 0);
    @(posedge clk); #1;

    // partial frame, then last on the very first item
    a_beat(2'd3, 1'b0, 1'b0);
    a_beat(2'd1, 1'b1, 1'b0);
    @(negedge clk);
    chk("part_vld", a_ovld, 1);
    chk("part_data", a_dout, pack4(3, 1, 0, 0));
    chk("part_mask", a_mask, 4'h3);
    chk("part_last", a_olast, 1);
    @(posedge clk); #1;
    a_beat(2'd2, 1'b1, 1'b0);
    @(negedge clk);
    chk("first_last_data", a_dout, pack4(2, 0, 0, 0));
    chk("first_last_mask", a_mask, 4'h1);
    chk("first_last_last", a_olast, 1);
    @(posedge clk); #1;

    // backpressure
    a_ordy = 1'b0;
    a_beat(2'd0, 1'b0, 1'b0);
    a_beat(2'd1, 1'b0, 1'b0);
    a_beat(2'd2, 1'b0, 1'b0);
    a_beat(2'd3, 1'b0, 1'b0);
    a_beat(2'd1, 1'b0, 1'b0);
    a_beat(2'd1, 1'b0, 1'b0);
    a_beat(2'd2, 1'b0, 1'b0);
    a_din = 2'd3; a_last = 1'b0; a_vld = 1'b1;
    @(negedge clk);
    chk("bp_rd_low", a_rd, 0);
    chk("bp_held_vld", a_ovld, 1);
    chk("bp_held_data", a_dout, pack4(0, 1, 2, 3));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_rd_low2", a_rd, 0);
    chk("bp_held_data2", a_dout, pack4(0, 1, 2, 3));
    @(posedge clk); #1;
    a_ordy = 1'b1;
    @(negedge clk);
    chk("bp_rd_release", a_rd, 1);
    @(posedge clk); #1;
    a_vld = 1'b0;
    @(negedge clk);
    chk("bp_w2_vld", a_ovld, 1);
    chk("bp_w2_data", a_dout, pack4(1, 1, 2, 3));
    chk("bp_w2_mask", a_mask, 4'hF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_drained", a_ovld, 0);
    @(posedge clk); #1;

    // streaming without bubbles
    foreach (s[i]) s[i] = int'($urandom_range(0, 3));
    for (int i = 0; i < 16; i++) begin
      a_vld = 1'b1; a_din = 2'(s[i]); a_last = 1'b0;
      @(negedge clk);
      chk("stream_rd", a_rd, 1);
      chk("stream_vld", a_ovld, (i > 0 && i % 4 == 0) ? 1 : 0);
      if (i > 0 && i % 4 == 0)
        chk("stream_data", a_dout, pack4(s[i-4], s[i-3], s[i-2], s[i-1]));
      @(posedge clk); #1;
    end
    a_vld = 1'b0;
    @(negedge clk);
    chk("stream_last_vld", a_ovld, 1);
    chk("stream_last_data", a_dout, pack4(s[12], s[13], s[14], s[15]));
    @(posedge clk); #1;

    // reset mid-word
    a_beat(2'd3, 1'b0, 1'b0);
    a_beat(2'd3, 1'b0, 1'b0);
    rst = 1'b1; a_vld = 1'b1; a_din = 2'd2;
    @(negedge clk);
    chk("midrst_rd", a_rd, 0);
    @(posedge clk); #1;
    rst = 1'b0; a_vld = 1'b0;
    @(negedge clk);
    chk("midrst_no_emit", a_ovld, 0);
    @(posedge clk); #1;
    a_beat(2'd1, 1'b0, 1'b0);
    a_beat(2'd0, 1'b0, 1'b0);
    a_beat(2'd2, 1'b0, 1'b0);
    a_beat(2'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_vld", a_ovld, 1);
    chk("midrst_data", a_dout, pack4(1, 0, 2, 1));
    chk("midrst_mask", a_mask, 4'hF);
    @(posedge clk); #1;

    // randomized frames against a queue model
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mon_a_en = 1'b1;
    wd = '0; wm = '0; cnt = 0;
    for (int i = 0; i < 60; i++) begin
      d = 2'($urandom_range(0, 3));
      l = (i == 59) || ($urandom_range(0, 4) == 0);
      wd = wd | (8'(d) << (2 * cnt));
      wm = wm | (4'(1) << cnt);
      cnt++;
      if (cnt == 4 || l) begin
        a_exp.push_back({l, wm, wd});
        wd = '0; wm = '0; cnt = 0;
      end
      if ($urandom_range(0, 3) == 0) begin
        a_ordy = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      a_beat(d, l, 1'b1);
    end
    a_ordy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    mon_a_en = 1'b0;
    chk("rand_a_count", a_obs.size(), a_exp.size());
    for (int i = 0; i < a_exp.size() && i < a_obs.size(); i++)
      chk("rand_a_word", a_obs[i], a_exp[i]);

    // single-item configuration: plain registered stage
    b_ordy = 1'b1;
    b_beat(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    chk("b_lat_vld", b_ovld, 1);
    chk("b_lat_data", b_dout, 8'h5A);
    chk("b_lat_mask", b_mask, 1);
    @(posedge clk); #1;
    mon_b_en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      bd = (i == 0) ? 8'h5A : (i == 1) ? 8'hC3 : 8'($urandom_range(0, 255));
      l = 1'($urandom_range(0, 1));
      b_exp.push_back({l, 1'b1, bd});
      b_beat(bd, l, 1'b1);
    end
    b_ordy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mon_b_en = 1'b0;
    chk("rand_b_count", b_obs.size(), b_exp.size());
    for (int i = 0; i < b_exp.size() && i < b_obs.size(); i++)
      chk("rand_b_item", b_obs[i], b_exp[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handshaked_width_upsizer.md
Name: handshaked_width_upsizer

Overview:
Downstream stage for the parametrized DATA_WIDTH data-path units. It takes a valid/ready stream of DATA_WIDTH-bit items and packs ITEMS consecutive items into one DATA_WIDTH*ITEMS-bit output word. A dataIn_last marker flushes a partially filled word with a per-item valid mask. Full throughput is one input item per clock, with registered output and backpressure.

Parameters:
DATA_WIDTH, 2, width of one input item in bits (>=1)
ITEMS, 4, items per output word (>=1); output data width = DATA_WIDTH*ITEMS

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
dataIn_data  input  DATA_WIDTH  input item
dataIn_last  input  1  item is the last of a frame; flushes the current word
dataIn_vld  input  1  input item valid
dataIn_rd  output  1  input ready; transfer when dataIn_vld & dataIn_rd
dataOut_data  output  DATA_WIDTH*ITEMS  packed word; item k at bits [k*DATA_WIDTH +: DATA_WIDTH]
dataOut_mask  output  ITEMS  bit k = item k holds valid data
dataOut_last  output  1  word closed by dataIn_last
dataOut_vld  output  1  output word valid
dataOut_rd  input  1  downstream ready; transfer when dataOut_vld & dataOut_rd

Behaviour:
- State registers:
  - idx: item index counter, width max(1, log2ceil(ITEMS)).
  - acc_data / acc_mask: accumulator.
  - out_data / out_mask / out_last / out_vld: output register.
- Reset (rst=1 at an edge): idx=0, acc_data=0, acc_mask=0, out_vld=0, out_data=0, out_mask=0, out_last=0.
  - dataIn_rd is forced 0 while rst=1.
  - Reset mid-word discards accumulated items and any pending output word, with no partial emission.
- Item ordering: the first item of a word lands in the LSBs (little-endian item order).
- A "completing beat" is an accepted input with idx==ITEMS-1 or dataIn_last=1.
- dataIn_rd (combinational, rst=0):
  - 1 if the current beat is not completing.
  - Otherwise 1 iff (!out_vld | dataOut_rd).
  - Non-completing beats are never stalled.
- Non-completing accepted beat: acc_data slot idx <= dataIn_data; acc_mask[idx] <= 1; idx <= idx+1.
- Completing accepted beat:
  - out_data <= acc_data with slot idx replaced by dataIn_data.
  - out_mask <= acc_mask | (1<<idx); out_last <= dataIn_last; out_vld <= 1.
  - acc_data <= 0; acc_mask <= 0; idx <= 0.
- Unused (unmasked) slots of dataOut_data are 0.
- Output register:
  - out_vld clears on dataOut_vld & dataOut_rd unless a completing beat is accepted in the same cycle, in which case it reloads.
  - out_* hold stable while out_vld=1 and dataOut_rd=0.
- Latency: a completing beat accepted at edge t gives dataOut_vld=1 from t to t+1, i.e. visible one cycle after acceptance.
- Throughput: with dataOut_rd=1 permanently, one item accepted every cycle and one word every ITEMS cycles; there are no bubbles at word boundaries.
- Backpressure: out_vld=1 with dataOut_rd=0 stalls only the completing beat. Up to ITEMS-1 items of the next word still accumulate.
- dataIn_last at idx==ITEMS-1: one full word with mask all ones and dataOut_last=1; no extra empty word.
- dataIn_last at idx==0: one word with mask = 1 (only item 0 valid).
- ITEMS=1: every beat is completing, giving a plain registered valid/ready stage with mask=1.
- dataIn_data / dataIn_last are ignored when dataIn_vld=0. dataOut_rd is ignored when out_vld=0.

Test Plan:
- DATA_WIDTH=2, ITEMS=4, dataOut_rd=1; feed 1,2,3,0 (last=0) -> next cycle dataOut_data=0x39, mask=0xF, last=0, vld for exactly 1 cycle.
- Partial frame: feed 3, then 1 with last=1 -> dataOut_data=0x07, mask=0x3, last=1; next frame starts at idx 0.
- Backpressure: dataOut_rd=0 with one word held; feed 8 items -> items 5..7 accepted, item 8 sees dataIn_rd=0 and out data stable; raise dataOut_rd -> item 8 accepted that cycle, second word valid next cycle.
- Streaming: 16 continuous items, dataOut_rd=1 -> dataIn_rd constantly 1, 4 words with vld one cycle after beats 4, 8, 12 and 16.
- Reset mid-word: accept 2 items, pulse rst 1 cycle (dataIn_rd=0 during it), then feed A,B,C,D -> single word packed from A..D only, mask=0xF, no stale data.
- ITEMS=1, DATA_WIDTH=8: items 0x5A, 0xC3 with random dataOut_rd -> outputs 0x5A, 0xC3 in order, mask=1, no loss or duplication.
